// File: rtl/block_ram_reader_pkg.sv
// Shared types and constants for the block_ram read DMA engine.
// RAM_READER_LOOP_EN (optional) enables continuous looping in block_ram_reader.
package block_ram_reader_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain
   } state_t;

   localparam int unsigned FIFO_DEPTH = 4;
   localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;

endpackage

// File: rtl/block_ram_reader_fifo.sv
// Small synchronous FIFO of {last, data} entries with occupancy count and flush.
// No RAM_READER_LOOP_EN dependency; the loop option lives in block_ram_reader.
module block_ram_reader_fifo
   import block_ram_reader_pkg::*;
#(
   parameter int unsigned data_width = 16
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_flush,
   input  logic                  i_wr_en,
   input  logic [data_width-1:0] i_wr_data,
   input  logic                  i_wr_last,
   input  logic                  i_rd_en,
   output logic                  o_valid,
   output logic [data_width-1:0] o_data,
   output logic                  o_last,
   output logic [FIFO_CNT_W-1:0] o_count
);

   logic [data_width:0]   r_mem [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] r_wr_ptr;
   logic [FIFO_PTR_W-1:0] r_rd_ptr;
   logic [FIFO_CNT_W-1:0] r_count;
   logic                  w_rd;

   assign w_rd = i_rd_en && (r_count != '0);

   always_ff @(posedge i_clock) begin
      if (i_wr_en) begin
         r_mem[r_wr_ptr] <= {i_wr_last, i_wr_data};
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_wr_en) begin
            r_wr_ptr <= r_wr_ptr + FIFO_PTR_W'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + FIFO_PTR_W'(1);
         end
         case ({i_wr_en, w_rd})
            2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
            2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      o_valid          = (r_count != '0);
      {o_last, o_data} = r_mem[r_rd_ptr];
      o_count          = r_count;
   end

endmodule

// File: rtl/block_ram_reader.sv
// Read-side DMA for block_ram: issues reads, absorbs 1-cycle latency, streams words out.
// Define RAM_READER_LOOP_EN to add i_loop (repeat the transfer until stopped).
module block_ram_reader
   import block_ram_reader_pkg::*;
#(
   parameter int unsigned addr_width = 8,
   parameter int unsigned data_width = 16
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [addr_width-1:0] i_base_addr,
   input  logic [addr_width:0]   i_length,
   input  logic                  i_stop,
`ifdef RAM_READER_LOOP_EN
   input  logic                  i_loop,
`endif
   output logic                  o_busy,
   output logic                  o_done,
   output logic [addr_width-1:0] o_ram_raddr,
   input  logic [data_width-1:0] i_ram_rdata,
   output logic                  o_out_valid,
   output logic [data_width-1:0] o_out_data,
   output logic                  o_out_last,
   input  logic                  i_out_ready
);

   state_t                r_state;
   state_t                w_state_next;
   logic [addr_width-1:0] r_addr, r_base, r_raddr, w_cur_addr, w_reload_addr;
   logic [addr_width:0]   r_remaining, r_length, w_cur_rem, w_reload_len;
   logic                  r_loop, w_cur_loop, w_loop_in;
   logic                  r_iss, r_iss_last, r_tag, r_tag_last, r_done;
   logic                  w_issue, w_issue_last, w_has_credit, w_flush, w_last_hs;
   logic                  w_fifo_last;
   logic [FIFO_CNT_W-1:0] w_fifo_count, w_credit_used;

`ifdef RAM_READER_LOOP_EN
   assign w_loop_in = i_loop;
`else
   assign w_loop_in = 1'b0;
`endif

   // Credits: words buffered plus reads still travelling through RAM and the tag stage.
   assign w_credit_used = w_fifo_count + FIFO_CNT_W'(r_iss) + FIFO_CNT_W'(r_tag);
   assign w_has_credit  = (w_credit_used < FIFO_CNT_W'(FIFO_DEPTH));

   always_comb begin
      w_cur_addr    = r_addr;
      w_cur_rem     = r_remaining;
      w_cur_loop    = r_loop;
      w_reload_addr = r_base;
      w_reload_len  = r_length;
      w_issue       = 1'b0;
      if (r_state == StIdle) begin
         w_cur_addr    = i_base_addr;
         w_cur_rem     = i_length;
         w_cur_loop    = w_loop_in;
         w_reload_addr = i_base_addr;
         w_reload_len  = i_length;
         w_issue       = i_start && (i_length != '0) && w_has_credit;
      end else if (r_state == StRun) begin
         w_issue = !i_stop && w_has_credit;
      end
      w_issue_last = (w_cur_rem == (addr_width + 1)'(1));
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_issue) begin
               w_state_next = (w_issue_last && !w_cur_loop) ? StDrain : StRun;
            end
         end
         StRun: begin
            if (i_stop) begin
               w_state_next = StIdle;
            end else if (w_issue && w_issue_last && !w_cur_loop) begin
               w_state_next = StDrain;
            end
         end
         StDrain: begin
            if (i_stop || w_last_hs) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      o_busy      = (r_state != StIdle);
      o_done      = r_done;
      o_ram_raddr = r_raddr;
      o_out_last  = o_out_valid && w_fifo_last;
      w_flush     = i_stop && o_busy;
      w_last_hs   = o_out_valid && i_out_ready && o_out_last;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_addr      <= '0;
         r_base      <= '0;
         r_raddr     <= '0;
         r_remaining <= '0;
         r_length    <= '0;
         r_loop      <= 1'b0;
         r_iss       <= 1'b0;
         r_iss_last  <= 1'b0;
         r_tag       <= 1'b0;
         r_tag_last  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == StIdle && i_start) begin
            r_base   <= i_base_addr;
            r_length <= i_length;
            r_loop   <= w_loop_in;
            if (i_length == '0) begin
               r_done <= 1'b1;
            end
         end
         if (r_state == StDrain && w_last_hs && !i_stop) begin
            r_done <= 1'b1;
         end
         if (w_issue) begin
            r_raddr <= w_cur_addr;
            if (w_issue_last) begin
               r_addr      <= w_reload_addr;
               r_remaining <= w_reload_len;
            end else begin
               r_addr      <= w_cur_addr + addr_width'(1);
               r_remaining <= w_cur_rem - (addr_width + 1)'(1);
            end
         end
         // Tags follow raddr through the RAM's read register so rdata is captured only for real reads.
         r_iss      <= w_issue;
         r_iss_last <= w_issue && w_issue_last;
         r_tag      <= r_iss && !w_flush;
         r_tag_last <= r_iss_last;
      end
   end

   block_ram_reader_fifo #(
      .data_width (data_width)
   ) u_fifo (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_flush   (w_flush),
      .i_wr_en   (r_tag),
      .i_wr_data (i_ram_rdata),
      .i_wr_last (r_tag_last),
      .i_rd_en   (i_out_ready),
      .o_valid   (o_out_valid),
      .o_data    (o_out_data),
      .o_last    (w_fifo_last),
      .o_count   (w_fifo_count)
   );

endmodule
